// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned FS_TO_DS_BUS_WD = 96;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1C00_0000;

    // Bundle handed from fetch to decode.
    typedef struct packed {
        logic [XLEN-1:0] pred_pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fs_to_ds_bus_t;

    // Static not-taken prediction: sequential successor, wraps modulo 2^32.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: SRAM request/response, decode handshake and branch redirect.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            ds_allowin;
    logic            br_taken_cancel;
    logic [XLEN-1:0] next_PC;

    logic            inst_sram_en;
    logic [3:0]      inst_sram_we;
    logic [XLEN-1:0] inst_sram_addr;
    logic [XLEN-1:0] inst_sram_wdata;
    logic [XLEN-1:0] inst_sram_rdata;

    logic            fs_to_ds_valid;
    logic [XLEN-1:0] fs_to_ds_pc;
    logic [XLEN-1:0] fs_to_ds_inst;
    logic [XLEN-1:0] fs_to_ds_pred_pc;

    modport master (
        input  ds_allowin, br_taken_cancel, next_PC, inst_sram_rdata,
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_pred_pc
    );

    modport slave (
        output ds_allowin, br_taken_cancel, next_PC, inst_sram_rdata,
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_pred_pc
    );

endinterface

// File: rtl/fetch_stage.sv
// Two-step fetch: pre-IF issues the SRAM read for nextpc, IF holds the returned word
// (buffering it across decode stalls) and presents it to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic            fs_valid;
    logic [XLEN-1:0] fs_pc;
    logic            buf_valid;
    logic [XLEN-1:0] inst_buf;

    logic            fs_ready_go;
    logic            fs_allowin;
    logic [XLEN-1:0] nextpc;
    logic            fs_to_ds_valid;
    fs_to_ds_bus_t   fs_to_ds_bus;

    // Pre-IF: redirect wins over the sequential prediction.
    always_comb begin
        fs_ready_go    = 1'b1;
        fs_allowin     = ~fs_valid | (fs_ready_go & bus.ds_allowin) | bus.br_taken_cancel;
        nextpc         = bus.br_taken_cancel ? bus.next_PC : seq_pc(fs_pc);
        fs_to_ds_valid = fs_valid & fs_ready_go & ~bus.br_taken_cancel;
    end

    always_comb begin
        fs_to_ds_bus.pc      = fs_pc;
        fs_to_ds_bus.inst    = buf_valid ? inst_buf : bus.inst_sram_rdata;
        fs_to_ds_bus.pred_pc = seq_pc(fs_pc);
    end

    assign bus.inst_sram_en     = ~reset & fs_allowin;
    assign bus.inst_sram_we     = 4'h0;
    assign bus.inst_sram_addr   = nextpc;
    assign bus.inst_sram_wdata  = '0;
    assign bus.fs_to_ds_valid   = fs_to_ds_valid;
    assign bus.fs_to_ds_pc      = fs_to_ds_bus.pc;
    assign bus.fs_to_ds_inst    = fs_to_ds_bus.inst;
    assign bus.fs_to_ds_pred_pc = fs_to_ds_bus.pred_pc;

    // IF stage register: advances on every issued request.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - XLEN'(4);
        end else if (fs_allowin) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end
    end

    // SRAM data is only valid for one cycle; capture it when decode stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            inst_buf  <= '0;
        end else if (bus.br_taken_cancel || (fs_to_ds_valid && bus.ds_allowin)) begin
            buf_valid <= 1'b0;
        end else if (fs_valid && !bus.ds_allowin && !buf_valid) begin
            buf_valid <= 1'b1;
            inst_buf  <= bus.inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a transaction-level model of the presented instruction stream.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if fsif();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fsif)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Instruction memory contents, distinct per word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // SRAM returns data one cycle after a request; otherwise the bus carries junk.
    always @(posedge clk) begin
        if (fsif.inst_sram_en) fsif.inst_sram_rdata <= mem_word(fsif.inst_sram_addr);
        else                   fsif.inst_sram_rdata <= $urandom;
    end

    // Model: which PC sits in IF (if any); expected outputs for the current cycle.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = RST_PC - 32'd4;
    logic        exp_en, exp_valid;
    logic [31:0] exp_addr, exp_pc, exp_inst, exp_pred;

    task automatic drive(input logic r, input logic a, input logic c, input logic [31:0] npc);
        @(negedge clk);
        reset                = r;
        fsif.ds_allowin      = a;
        fsif.br_taken_cancel = c;
        fsif.next_PC         = npc;
        #1;
        exp_en    = !r && (!m_valid || a || c);
        exp_addr  = c ? npc : m_pc + 32'd4;
        exp_valid = m_valid && !c;
        exp_pc    = m_pc;
        exp_pred  = m_pc + 32'd4;
        exp_inst  = mem_word(m_pc);
        if (r) begin
            m_valid = 1'b0;
            m_pc    = RST_PC - 32'd4;
        end else if (exp_en) begin
            m_valid = 1'b1;
            m_pc    = exp_addr;
        end
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tests_run++;
            if (fsif.inst_sram_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_en got %0b want 0", fsif.inst_sram_en);
            end
            tests_run++;
            if (fsif.fs_to_ds_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_valid got %0b want 0", fsif.fs_to_ds_valid);
            end
            tests_run++;
            if (fsif.fs_to_ds_pc !== RST_PC - 32'd4) begin
                tests_failed++;
                $display("FAIL reset_pc got %h want %h", fsif.fs_to_ds_pc, RST_PC - 32'd4);
            end
            tests_run++;
            if (fsif.inst_sram_we !== 4'h0 || fsif.inst_sram_wdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_we_wdata got %h/%h want 0/0", fsif.inst_sram_we, fsif.inst_sram_wdata);
            end
        end
    endtask

    task automatic test_sequence;
        logic [31:0] addrs [3];
        addrs[0] = 32'h1C00_0000;
        addrs[1] = 32'h1C00_0004;
        addrs[2] = 32'h1C00_0008;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            tests_run++;
            if (fsif.inst_sram_en !== 1'b1 || fsif.inst_sram_addr !== addrs[i]) begin
                tests_failed++;
                $display("FAIL seq_addr%0d got en=%0b addr=%h want en=1 addr=%h",
                         i, fsif.inst_sram_en, fsif.inst_sram_addr, addrs[i]);
            end
            tests_run++;
            if (fsif.fs_to_ds_valid !== (i != 0)) begin
                tests_failed++;
                $display("FAIL seq_valid%0d got %0b want %0b", i, fsif.fs_to_ds_valid, i != 0);
            end
            if (i != 0) begin
                tests_run++;
                if (fsif.fs_to_ds_pc !== addrs[i-1] || fsif.fs_to_ds_pred_pc !== addrs[i]
                    || fsif.fs_to_ds_inst !== mem_word(addrs[i-1])) begin
                    tests_failed++;
                    $display("FAIL seq_bundle%0d got pc=%h pred=%h inst=%h want pc=%h pred=%h inst=%h",
                             i, fsif.fs_to_ds_pc, fsif.fs_to_ds_pred_pc, fsif.fs_to_ds_inst,
                             addrs[i-1], addrs[i], mem_word(addrs[i-1]));
                end
            end
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            tests_run++;
            if (fsif.inst_sram_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_en%0d got %0b want 0", i, fsif.inst_sram_en);
            end
            tests_run++;
            if (fsif.fs_to_ds_valid !== 1'b1 || fsif.fs_to_ds_pc !== 32'h1C00_0008
                || fsif.fs_to_ds_inst !== mem_word(32'h1C00_0008)) begin
                tests_failed++;
                $display("FAIL stall_hold%0d got v=%0b pc=%h inst=%h want v=1 pc=1c000008 inst=%h",
                         i, fsif.fs_to_ds_valid, fsif.fs_to_ds_pc, fsif.fs_to_ds_inst,
                         mem_word(32'h1C00_0008));
            end
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_valid !== 1'b1 || fsif.fs_to_ds_inst !== mem_word(32'h1C00_0008)
            || fsif.inst_sram_en !== 1'b1 || fsif.inst_sram_addr !== 32'h1C00_000C) begin
            tests_failed++;
            $display("FAIL stall_release got v=%0b inst=%h en=%0b addr=%h want v=1 inst=%h en=1 addr=1c00000c",
                     fsif.fs_to_ds_valid, fsif.fs_to_ds_inst, fsif.inst_sram_en,
                     fsif.inst_sram_addr, mem_word(32'h1C00_0008));
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_pc !== 32'h1C00_000C || fsif.fs_to_ds_inst !== mem_word(32'h1C00_000C)) begin
            tests_failed++;
            $display("FAIL stall_once got pc=%h inst=%h want pc=1c00000c inst=%h",
                     fsif.fs_to_ds_pc, fsif.fs_to_ds_inst, mem_word(32'h1C00_000C));
        end
    endtask

    task automatic test_cancel;
        drive(1'b0, 1'b1, 1'b1, 32'h1C00_0100);
        tests_run++;
        if (fsif.fs_to_ds_valid !== 1'b0 || fsif.inst_sram_en !== 1'b1
            || fsif.inst_sram_addr !== 32'h1C00_0100) begin
            tests_failed++;
            $display("FAIL cancel_redirect got v=%0b en=%0b addr=%h want v=0 en=1 addr=1c000100",
                     fsif.fs_to_ds_valid, fsif.inst_sram_en, fsif.inst_sram_addr);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_valid !== 1'b1 || fsif.fs_to_ds_pc !== 32'h1C00_0100
            || fsif.fs_to_ds_inst !== mem_word(32'h1C00_0100)) begin
            tests_failed++;
            $display("FAIL cancel_target got v=%0b pc=%h inst=%h want v=1 pc=1c000100 inst=%h",
                     fsif.fs_to_ds_valid, fsif.fs_to_ds_pc, fsif.fs_to_ds_inst, mem_word(32'h1C00_0100));
        end
    endtask

    task automatic test_cancel_in_stall;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (fsif.inst_sram_en !== 1'b0 || fsif.fs_to_ds_inst !== mem_word(32'h1C00_0104)) begin
            tests_failed++;
            $display("FAIL cis_buffered got en=%0b inst=%h want en=0 inst=%h",
                     fsif.inst_sram_en, fsif.fs_to_ds_inst, mem_word(32'h1C00_0104));
        end
        drive(1'b0, 1'b0, 1'b1, 32'h1C00_0200);
        tests_run++;
        if (fsif.fs_to_ds_valid !== 1'b0 || fsif.inst_sram_en !== 1'b1
            || fsif.inst_sram_addr !== 32'h1C00_0200) begin
            tests_failed++;
            $display("FAIL cis_redirect got v=%0b en=%0b addr=%h want v=0 en=1 addr=1c000200",
                     fsif.fs_to_ds_valid, fsif.inst_sram_en, fsif.inst_sram_addr);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_valid !== 1'b1 || fsif.fs_to_ds_pc !== 32'h1C00_0200
            || fsif.fs_to_ds_inst !== mem_word(32'h1C00_0200)) begin
            tests_failed++;
            $display("FAIL cis_dropped got v=%0b pc=%h inst=%h want v=1 pc=1c000200 inst=%h",
                     fsif.fs_to_ds_valid, fsif.fs_to_ds_pc, fsif.fs_to_ds_inst, mem_word(32'h1C00_0200));
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 1'b1, 1'b1, 32'h1C00_0300);
        drive(1'b0, 1'b0, 1'b1, 32'h1C00_0400);
        tests_run++;
        if (fsif.fs_to_ds_valid !== 1'b0 || fsif.inst_sram_addr !== 32'h1C00_0400) begin
            tests_failed++;
            $display("FAIL b2b_second got v=%0b addr=%h want v=0 addr=1c000400",
                     fsif.fs_to_ds_valid, fsif.inst_sram_addr);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_pc !== 32'h1C00_0400 || fsif.fs_to_ds_inst !== mem_word(32'h1C00_0400)) begin
            tests_failed++;
            $display("FAIL b2b_last got pc=%h inst=%h want pc=1c000400 inst=%h",
                     fsif.fs_to_ds_pc, fsif.fs_to_ds_inst, mem_word(32'h1C00_0400));
        end
    endtask

    task automatic test_wrap;
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_pc !== 32'hFFFF_FFFC || fsif.fs_to_ds_pred_pc !== 32'h0
            || fsif.inst_sram_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap got pc=%h pred=%h addr=%h want pc=fffffffc pred=0 addr=0",
                     fsif.fs_to_ds_pc, fsif.fs_to_ds_pred_pc, fsif.inst_sram_addr);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_pc !== 32'h0 || fsif.fs_to_ds_inst !== mem_word(32'h0)) begin
            tests_failed++;
            $display("FAIL wrap_next got pc=%h inst=%h want pc=0 inst=%h",
                     fsif.fs_to_ds_pc, fsif.fs_to_ds_inst, mem_word(32'h0));
        end
    endtask

    task automatic test_reset_in_stall;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (fsif.inst_sram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL ris_en got %0b want 0", fsif.inst_sram_en);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ris_valid got %0b want 0", fsif.fs_to_ds_valid);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fsif.inst_sram_en !== 1'b1 || fsif.inst_sram_addr !== RST_PC) begin
            tests_failed++;
            $display("FAIL ris_restart got en=%0b addr=%h want en=1 addr=%h",
                     fsif.inst_sram_en, fsif.inst_sram_addr, RST_PC);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (fsif.fs_to_ds_valid !== 1'b1 || fsif.fs_to_ds_pc !== RST_PC
            || fsif.fs_to_ds_inst !== mem_word(RST_PC)) begin
            tests_failed++;
            $display("FAIL ris_first got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                     fsif.fs_to_ds_valid, fsif.fs_to_ds_pc, fsif.fs_to_ds_inst, RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_random;
        logic        r, a, c;
        logic [31:0] tmp, npc;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(99) < 3);
            a   = ($urandom_range(99) < 70);
            c   = ($urandom_range(99) < 15);
            tmp = $urandom;
            npc = {tmp[31:2], 2'b00};
            drive(r, a, c, npc);
            tests_run++;
            if (fsif.inst_sram_en !== exp_en) begin
                tests_failed++;
                $display("FAIL rnd_en cyc%0d got %0b want %0b", i, fsif.inst_sram_en, exp_en);
            end
            if (exp_en) begin
                tests_run++;
                if (fsif.inst_sram_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL rnd_addr cyc%0d got %h want %h", i, fsif.inst_sram_addr, exp_addr);
                end
            end
            tests_run++;
            if (fsif.fs_to_ds_valid !== exp_valid) begin
                tests_failed++;
                $display("FAIL rnd_valid cyc%0d got %0b want %0b", i, fsif.fs_to_ds_valid, exp_valid);
            end
            if (exp_valid) begin
                tests_run++;
                if (fsif.fs_to_ds_pc !== exp_pc || fsif.fs_to_ds_pred_pc !== exp_pred
                    || fsif.fs_to_ds_inst !== exp_inst) begin
                    tests_failed++;
                    $display("FAIL rnd_bundle cyc%0d got pc=%h pred=%h inst=%h want pc=%h pred=%h inst=%h",
                             i, fsif.fs_to_ds_pc, fsif.fs_to_ds_pred_pc, fsif.fs_to_ds_inst,
                             exp_pc, exp_pred, exp_inst);
                end
            end
        end
    endtask

    initial begin
        reset                = 1'b1;
        fsif.ds_allowin      = 1'b1;
        fsif.br_taken_cancel = 1'b0;
        fsif.next_PC         = 32'h0;
        test_reset();
        test_sequence();
        test_stall();
        test_cancel();
        test_cancel_in_stall();
        test_back_to_back();
        test_wrap();
        test_reset_in_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C000000, the address of the first fetched instruction.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ds_allowin  in  1  decode stage can accept an instruction this cycle.
REQ-006 br_taken_cancel  in  1  branch misprediction from the branch unit; redirect fetch.
REQ-007 next_PC  in  32  correct target address, valid when br_taken_cancel=1.
REQ-008 inst_sram_en  out  1  instruction SRAM read request.
REQ-009 inst_sram_we  out  4  SRAM byte write enable, constant 0.
REQ-010 inst_sram_addr  out  32  SRAM read address (nextpc).
REQ-011 inst_sram_wdata  out  32  constant 0.
REQ-012 inst_sram_rdata  in  32  read data, returned exactly one cycle after the request.
REQ-013 fs_to_ds_valid  out  1  instruction bundle valid toward decode.
REQ-014 fs_to_ds_pc  out  32  PC of the bundled instruction.
REQ-015 fs_to_ds_inst  out  32  instruction word.
REQ-016 fs_to_ds_pred_pc  out  32  predicted next PC (fs_pc+4); carried down the pipe to the branch unit as pred_PC.

Function
REQ-017 Two internal stages: pre-IF (computes nextpc, issues SRAM request) and IF (registers fs_valid, fs_pc, holds returned instruction).
REQ-018 nextpc = next_PC when br_taken_cancel=1, else fs_pc+4 (static not-taken prediction); 32-bit add, wraps modulo 2^32 with no error.
REQ-019 fs_ready_go = 1 always; fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken_cancel.
REQ-020 inst_sram_en = ~reset & fs_allowin; on an enabled cycle fs_valid<=1 and fs_pc<=nextpc at the next edge; otherwise fs_valid and fs_pc hold.
REQ-021 fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken_cancel.
REQ-022 fs_to_ds_inst = inst_buf when buf_valid=1, else inst_sram_rdata.
REQ-023 Instruction buffer: when fs_valid=1, ds_allowin=0, buf_valid=0 and no cancel, inst_buf<=inst_sram_rdata and buf_valid<=1; buf_valid clears when the instruction is accepted (fs_to_ds_valid & ds_allowin) or on cancel.
REQ-024 Stall: while ds_allowin=0 and no cancel, fs_pc, fs_valid, inst_buf and outputs stay constant; no new SRAM request.
REQ-025 Cancel: on br_taken_cancel=1 the IF instruction is discarded (not presented to decode), buf_valid cleared, and a request to next_PC issued the same cycle regardless of ds_allowin.
REQ-026 Cancel in the same cycle as a stall or a pending buffered instruction: cancel wins; buffered word dropped.
REQ-027 Back-to-back cancels: each cancel redirects; the last one's next_PC is the address fetched.
REQ-028 Throughput: one instruction per cycle when ds_allowin=1 continuously; first instruction latency after reset release = 1 cycle (request) + presented the following cycle.

Reset
REQ-029 While reset=1: fs_valid=0, buf_valid=0, fs_pc=RESET_PC-4, inst_buf=0, inst_sram_en=0, fs_to_ds_valid=0.
REQ-030 First request after reset deasserts SHALL be to RESET_PC.
REQ-031 Reset asserted mid-stall or mid-cancel SHALL discard all state within the same cycle's edge; no partial bundle emitted.

Structure
REQ-032 RESET_PC default and the fs_to_ds bus width (FS_TO_DS_BUS_WD = 96) SHALL live in the shared header include/myCPU.h.
REQ-033 Single module; no sub-module; instruction buffer implemented inline.

Verification
REQ-034 Reset release, ds_allowin=1 -> inst_sram_addr sequence 1C000000, 1C000004, 1C000008; fs_to_ds_pred_pc = pc+4 each cycle.
REQ-035 ds_allowin=0 for 3 cycles while fs_pc=1C000008 -> inst_sram_en=0, fs_to_ds_inst equals the word returned at stall start, unchanged; on release it is delivered once, next addr 1C00000C.
REQ-036 br_taken_cancel=1, next_PC=1C000100 while fs_valid=1 -> fs_to_ds_valid=0 that cycle, inst_sram_addr=1C000100, next bundle pc=1C000100.
REQ-037 Cancel during stall with buf_valid=1 -> buffer dropped, request to next_PC issued despite ds_allowin=0.
REQ-038 fs_pc=FFFFFFFC, no cancel -> nextpc=00000000.
REQ-039 Reset asserted while stalled with buf_valid=1 -> next cycle fs_to_ds_valid=0; after release first address RESET_PC.
